// File: rtl/rom_reader_pkg.sv
// Shared widths, state encoding and FIFO payload for the ROM stream reader.
package rom_reader_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 9;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } rd_state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/rom_reader_fifo.sv
// Output buffer of {last, data} entries between the ROM capture point and the stream port.
module rom_reader_fifo
    import rom_reader_pkg::*;
#(
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  fifo_entry_t      wdata,
    input  logic             pop,
    output fifo_entry_t      rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fifo_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop_c  = pop & ~empty;
    // A push into a full buffer is legal only when the head leaves on the same edge.
    assign do_push_c = push & (~full | do_pop_c);
    assign rdata     = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        end
    end

endmodule

// File: rtl/rom_stream_reader.sv
// Reads LENGTH consecutive ROM words from BASE and streams them out with valid/ready,
// hiding the ROM read latency behind a credit-controlled output FIFO.
module rom_stream_reader
    import rom_reader_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    // The registered rom_address costs one edge on top of the ROM's own latency.
    localparam int unsigned TAG_STAGES = READ_LATENCY + 1;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W      = CNT_W + 1;

    rd_state_t             state;
    rd_state_t             state_nxt;
    logic [ADDR_W-1:0]     addr;
    logic [ADDR_W-1:0]     addr_nxt;
    logic [ADDR_W-1:0]     rom_address_nxt;
    logic [LEN_W-1:0]      remaining;
    logic [LEN_W-1:0]      remaining_nxt;
    logic [TAG_STAGES-1:0] tag_vld;
    logic [TAG_STAGES-1:0] tag_vld_nxt;
    logic [TAG_STAGES-1:0] tag_last;
    logic [TAG_STAGES-1:0] tag_last_nxt;
    logic [CNT_W-1:0]      inflight;
    logic [CNT_W-1:0]      inflight_nxt;
    logic                  busy_nxt;
    logic                  done_nxt;

    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    fifo_entry_t           fifo_head;
    fifo_entry_t           fifo_wdata;

    logic                  pop_c;
    logic                  capture_c;
    logic                  issue_c;
    logic                  credit_c;
    logic [SUM_W-1:0]      occupancy_c;

    assign m_valid   = ~fifo_empty;
    assign m_data    = fifo_head.data;
    assign m_last    = fifo_head.last;
    assign pop_c     = m_valid & m_ready;
    assign capture_c = tag_vld[TAG_STAGES-1];

    // Words buffered or still in the ROM pipe; a same-edge pop frees one slot.
    assign occupancy_c = SUM_W'(fifo_count) + SUM_W'(inflight);
    assign credit_c    = (~fifo_full | pop_c) &
                         (occupancy_c < SUM_W'(FIFO_DEPTH) + SUM_W'(pop_c));

    always_comb begin
        state_nxt       = state;
        addr_nxt        = addr;
        remaining_nxt   = remaining;
        rom_address_nxt = rom_address;
        busy_nxt        = busy;
        done_nxt        = 1'b0;
        issue_c         = 1'b0;
        tag_vld_nxt     = {tag_vld[TAG_STAGES-2:0], 1'b0};
        tag_last_nxt    = {tag_last[TAG_STAGES-2:0], 1'b0};

        unique case (state)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_nxt     = FETCH;
                        addr_nxt      = base_addr;
                        remaining_nxt = length;
                        busy_nxt      = 1'b1;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (credit_c) begin
                    issue_c         = 1'b1;
                    rom_address_nxt = addr;
                    addr_nxt        = addr + ADDR_W'(1);
                    remaining_nxt   = remaining - LEN_W'(1);
                    tag_vld_nxt[0]  = 1'b1;
                    tag_last_nxt[0] = (remaining == LEN_W'(1));
                    if (remaining == LEN_W'(1)) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop_c && fifo_head.last) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase

        inflight_nxt = inflight + CNT_W'(issue_c) - CNT_W'(capture_c);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            addr        <= '0;
            remaining   <= '0;
            rom_address <= '0;
            tag_vld     <= '0;
            tag_last    <= '0;
            inflight    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            addr        <= addr_nxt;
            remaining   <= remaining_nxt;
            rom_address <= rom_address_nxt;
            tag_vld     <= tag_vld_nxt;
            tag_last    <= tag_last_nxt;
            inflight    <= inflight_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

    assign fifo_wdata = '{last: tag_last[TAG_STAGES-1], data: rom_q};

    rom_reader_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (capture_c),
        .wdata   (fifo_wdata),
        .pop     (pop_c),
        .rdata   (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
